prop_monitor: RTL and testbench

- Synthesizable, parametrised multi-channel temporal property checker.
- Hardware successor to our simulation-only `a || b` concurrent assertions.
- Each channel watches a pair of signals `(a, b)` under a selectable property mode.
- Reports per-cycle fail pulses, sticky errors, saturating error counts and first-failure capture; sits beside datapath blocks as an on-chip checker readable by debug logic.

---
 rtl/prop_mon_pkg.sv | 28 ++
 rtl/prop_mon_ch.sv | 127 ++++++++++++
 rtl/prop_monitor.sv | 86 ++++++++
 tb/tb_prop_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prop_mon_pkg.sv
// rtl/prop_mon_pkg.sv - shared types and width helpers for the property monitor
package prop_mon_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_INV  = 2'b01,
        MODE_NEXT = 2'b10,
        MODE_BND  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bnd_state_e;

    localparam int unsigned CNT_W_DEFAULT = 8;

    // Width of the bounded-response delay counter: must hold 0..max_dly.
    function automatic int unsigned dly_width(input int unsigned max_dly);
        return $clog2(max_dly + 1);
    endfunction

    // Width of a channel index, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prop_mon_ch.sv
// rtl/prop_mon_ch.sv - one property-checking channel with sticky/count status
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           global check enable
//   clr          synchronous clear of status, FSM and pend
//   mode         requested property mode for this channel
//   a, b         antecedent / consequent terms
//   viol         combinational violation at the coming edge (pre-clr)
//   fail         registered one-cycle violation pulse
//   err_sticky   set on first violation, held until clr
//   err_cnt      saturating violation count
module prop_mon_ch
    import prop_mon_pkg::*;
#(
    parameter int unsigned MAX_DLY = 8,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             a,
    input  logic             b,
    output logic             viol,
    output logic             fail,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned       DLY_W   = dly_width(MAX_DLY);
    localparam logic [DLY_W-1:0]  DLY_MAX = DLY_W'(MAX_DLY);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    mode_e            mode_d;
    mode_e            mode_q;
    bnd_state_e       state_q;
    bnd_state_e       state_d;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dly_d;
    logic             pend_q;
    logic             pend_d;
    logic             mode_chg;

    assign mode_d   = mode_e'(mode);
    // A mode change blanks the channel for one edge so stale obligations
    // from the old mode can never fire under the new one.
    assign mode_chg = (mode_d != mode_q);

    always_comb begin
        state_d = ST_IDLE;
        dly_d   = '0;
        pend_d  = 1'b0;
        viol    = 1'b0;
        if (en && !mode_chg) begin
            case (mode_q)
                MODE_INV: begin
                    viol = !(a || b);
                end
                MODE_NEXT: begin
                    viol   = pend_q && !b;
                    pend_d = a;
                end
                MODE_BND: begin
                    case (state_q)
                        ST_IDLE: begin
                            if (a) begin
                                state_d = ST_WAIT;
                                dly_d   = DLY_W'(1);
                            end
                        end
                        ST_WAIT: begin
                            if (b) begin
                                // A fresh antecedent on the passing cycle re-arms.
                                if (a) begin
                                    state_d = ST_WAIT;
                                    dly_d   = DLY_W'(1);
                                end
                            end else if (dly_q == DLY_MAX) begin
                                viol = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                                dly_d   = dly_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_OFF;
            state_q    <= ST_IDLE;
            dly_q      <= '0;
            pend_q     <= 1'b0;
            fail       <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            mode_q     <= mode_d;
            state_q    <= ST_IDLE;
            dly_q      <= '0;
            pend_q     <= 1'b0;
            fail       <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
            fail    <= viol;
            if (viol) begin
                err_sticky <= 1'b1;
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prop_monitor.sv
// rtl/prop_monitor.sv - multi-channel temporal property checker top level
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           global check enable
//   clr          synchronous clear of all status and channel state
//   mode         2 bits per channel, channel i at [2i+1:2i]
//   a, b         per-channel terms
//   fail         per-channel one-cycle violation pulse
//   err_sticky   per-channel sticky error
//   err_cnt      CNT_W bits per channel, saturating
//   any_err      OR of err_sticky
//   first_vld    a failure has been captured since reset/clr
//   first_ch     lowest-index channel of the first captured failure
module prop_monitor
    import prop_mon_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MAX_DLY = 8,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    input  logic [2*NUM_CH-1:0]           mode,
    input  logic [NUM_CH-1:0]             a,
    input  logic [NUM_CH-1:0]             b,
    output logic [NUM_CH-1:0]             fail,
    output logic [NUM_CH-1:0]             err_sticky,
    output logic [CNT_W*NUM_CH-1:0]       err_cnt,
    output logic                          any_err,
    output logic                          first_vld,
    output logic [idx_width(NUM_CH)-1:0]  first_ch
);

    localparam int unsigned CH_W = idx_width(NUM_CH);

    logic [NUM_CH-1:0] viol;
    logic [CH_W-1:0]   first_idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        prop_mon_ch #(
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .clr        (clr),
            .mode       (mode[2*i +: 2]),
            .a          (a[i]),
            .b          (b[i]),
            .viol       (viol[i]),
            .fail       (fail[i]),
            .err_sticky (err_sticky[i]),
            .err_cnt    (err_cnt[CNT_W*i +: CNT_W])
        );
    end

    // Scan high to low so the lowest violating index is the one left standing.
    always_comb begin
        first_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (viol[i]) begin
                first_idx = CH_W'(i);
            end
        end
    end

    assign any_err = |err_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_vld <= 1'b0;
            first_ch  <= '0;
        end else if (clr) begin
            first_vld <= 1'b0;
            first_ch  <= '0;
        end else if (!first_vld && (|viol)) begin
            first_vld <= 1'b1;
            first_ch  <= first_idx;
        end
    end

endmodule

// File: tb/tb_prop_monitor.sv
// tb/tb_prop_monitor.sv - scoreboard testbench for prop_monitor
module tb_prop_monitor;

    localparam int NUM_CH  = 4;
    localparam int MAX_DLY = 8;
    localparam int CNT_W   = 2;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en    = 1'b0;
    logic                    clr   = 1'b0;
    logic [2*NUM_CH-1:0]     mode  = '0;
    logic [NUM_CH-1:0]       a     = '0;
    logic [NUM_CH-1:0]       b     = '0;
    logic [NUM_CH-1:0]       fail;
    logic [NUM_CH-1:0]       err_sticky;
    logic [CNT_W*NUM_CH-1:0] err_cnt;
    logic                    any_err;
    logic                    first_vld;
    logic [1:0]              first_ch;

    prop_monitor #(
        .NUM_CH  (NUM_CH),
        .MAX_DLY (MAX_DLY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .fail       (fail),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .any_err    (any_err),
        .first_vld  (first_vld),
        .first_ch   (first_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                edge_n;
        logic [NUM_CH-1:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Called just before the edge on which a violation is presented.
    task automatic expect_fail(input logic [NUM_CH-1:0] v);
        exp_t e;
        e.edge_n = cyc + 1;
        e.vec    = v;
        exp_q.push_back(e);
    endtask

    task automatic chk_status(input string name, input logic [3:0] st, input logic [7:0] cnt,
                              input logic fv, input logic [1:0] fc);
        chk({name, "_sticky"}, 32'(err_sticky), 32'(st));
        chk({name, "_cnt"}, 32'(err_cnt), 32'(cnt));
        chk({name, "_any"}, 32'(any_err), 32'(|st));
        chk({name, "_first_vld"}, 32'(first_vld), 32'(fv));
        chk({name, "_first_ch"}, 32'(first_ch), 32'(fc));
    endtask

    // Monitor: every fail pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
                checks++;
                errors++;
                $display("FAIL fail_missing: got 0x0 expected 0x%0h after edge %0d", exp_q[0].vec, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            if (fail !== '0) begin
                if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                    chk("fail_vec", 32'(fail), 32'(exp_q[0].vec));
                    void'(exp_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL fail_unexpected: got 0x%0h expected 0x0 after edge %0d", fail, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_fail", 32'(fail), 32'h0);
        chk_status("rst", 4'h0, 8'h00, 1'b0, 2'd0);
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        step();

        // INVARIANT on ch0: single violation
        mode = 8'b0000_0001; a = 4'b0001; b = 4'b0001;
        run(3);
        a[0] = 1'b0; b[0] = 1'b0;
        expect_fail(4'b0001);
        step();
        a[0] = 1'b1;
        run(2);
        chk_status("inv", 4'b0001, 8'h01, 1'b1, 2'd0);

        clr = 1'b1; step(); clr = 1'b0;
        chk_status("clr1", 4'b0000, 8'h00, 1'b0, 2'd0);

        // NEXT on ch1
        mode = 8'b0000_1000; a = 4'b0000; b = 4'b0000;
        step();
        a[1] = 1'b1; step();
        a[1] = 1'b0; b[1] = 1'b0;
        expect_fail(4'b0010);
        step();
        step();
        a[1] = 1'b1; b[1] = 1'b0; step();
        a[1] = 1'b1; b[1] = 1'b1; step();
        a[1] = 1'b0; b[1] = 1'b0;
        expect_fail(4'b0010);
        step();
        run(2);
        chk_status("next", 4'b0010, 8'h08, 1'b1, 2'd1);

        clr = 1'b1; step(); clr = 1'b0;

        // BOUNDED on ch2: b on the last window edge passes, then a timeout
        mode = 8'b0011_0000; a = 4'b0000; b = 4'b0000;
        step();
        a[2] = 1'b1; step();
        a[2] = 1'b0;
        run(7);
        b[2] = 1'b1; step();
        b[2] = 1'b0; step();
        a[2] = 1'b1; step();
        a[2] = 1'b0;
        run(2);
        a[2] = 1'b1; step();
        a[2] = 1'b0;
        run(4);
        expect_fail(4'b0100);
        step();
        run(12);
        chk_status("bnd", 4'b0100, 8'h10, 1'b1, 2'd2);

        clr = 1'b1; step(); clr = 1'b0;

        // Simultaneous ch1/ch3, then later ch0
        mode = 8'b0100_1001; a = 4'b1001; b = 4'b1001;
        step();
        a = 4'b1011; step();
        a = 4'b0001; b = 4'b0001;
        expect_fail(4'b1010);
        step();
        a = 4'b1001; b = 4'b1001; step();
        a = 4'b1000; b = 4'b1000;
        expect_fail(4'b0001);
        step();
        a = 4'b1001; b = 4'b1001; step();
        chk_status("simul", 4'b1011, 8'h45, 1'b1, 2'd1);

        // Saturation at 2^CNT_W-1
        mode = 8'b0000_0001; a = 4'b0001; b = 4'b0001;
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a[0] = 1'b0; b[0] = 1'b0;
            expect_fail(4'b0001);
            step();
        end
        a[0] = 1'b1; b[0] = 1'b1; step();
        chk_status("sat", 4'b0001, 8'h03, 1'b1, 2'd0);

        // clr on the same edge as a violation
        a[0] = 1'b0; b[0] = 1'b0; clr = 1'b1; step();
        clr = 1'b0; a[0] = 1'b1; b[0] = 1'b1; step();
        chk_status("clr_viol", 4'b0000, 8'h00, 1'b0, 2'd0);

        // en=0 suppresses checking
        en = 1'b0; a = 4'b0000; b = 4'b0000;
        run(3);
        en = 1'b1; a = 4'b0001; b = 4'b0001; step();
        chk("en_off_sticky", 32'(err_sticky), 32'h0);

        // Mode switch BOUNDED->INVARIANT mid-WAIT
        mode = 8'b0011_0000; a = 4'b0000; b = 4'b0000;
        step();
        a[2] = 1'b1; step();
        a[2] = 1'b0; run(3);
        mode = 8'b0001_0000; step();
        a[2] = 1'b1; run(10);
        chk("mode_sw_sticky", 32'(err_sticky), 32'h0);

        // Asynchronous reset mid-WAIT
        mode = 8'b0011_0001; a = 4'b0001; b = 4'b0001;
        step();
        a = 4'b0000; b = 4'b0000;
        expect_fail(4'b0001);
        step();
        a = 4'b0101; b = 4'b0001; step();
        a = 4'b0001; run(3);
        chk("pre_rst_sticky", 32'(err_sticky), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_fail", 32'(fail), 32'h0);
        chk_status("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
        step();
        step();
        rst_n = 1'b1;
        run(12);
        chk_status("post_rst", 4'b0000, 8'h00, 1'b0, 2'd0);

        run(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
